wm_program_loader: RTL and testbench
====================================

// Module: wm_program_loader
// PURPOSE
//   Writer side of the washing-machine processor's instruction interface. Receives a framed
//   program over a byte stream and writes it into the program store. Serves instr[31:0]
//   combinationally for the processor's pc. Holds the processor disabled while a load is in
//   progress and after any failed load.
// PARAMETERS
//   DEPTH          256   program words; pc is 8 bits, so DEPTH <= 256
//   TIMEOUT_CYCLES 1000  idle cycles allowed between bytes inside a frame before abort
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   rx_valid   in   1   byte strobe from the byte source
//   rx_data    in   8   received byte
//   rx_ready   out  1   loader accepts rx_data when rx_valid && rx_ready
//   pc         in   8   processor program counter
//   instr      out  32  {imm[15:0], reg[7:0], opcode[7:0]} at address pc
//   proc_ena   out  1   drives the processor's ena input
//   load_done  out  1   one-cycle pulse: frame accepted
//   load_err   out  1   one-cycle pulse: frame rejected
// BEHAVIOUR
//   Reset values: rx_ready=0, proc_ena=0, load_done=0, load_err=0, prog_len=0, state=IDLE.
//   Memory contents are not reset.
//   Frame format: 0xA5, N, 4*N instruction bytes, CK.
//   - Instruction bytes are little-endian, opcode byte first.
//   - CK makes the 8-bit sum (N + all instruction bytes + CK) == 0.
//   FSM:
//   - IDLE: non-0xA5 bytes are discarded. On 0xA5 -> LEN; proc_ena=0 and prog_len=0 from
//     the next cycle.
//   - LEN: if N==0 or N>DEPTH -> ERR; else sum=N, widx=0 -> DATA.
//   - DATA: bytes are shifted into a 32-bit assembler. On each 4th byte, write mem[widx]
//     (registered write, same edge) and increment widx. When widx reaches N -> CSUM.
//   - CSUM: if (sum+CK)&8'hFF == 0 -> DONE, else -> ERR.
//   - DONE (1 cycle): prog_len=N, proc_ena=1, load_done=1 -> IDLE.
//   - ERR (1 cycle): load_err=1, proc_ena stays 0, prog_len stays 0 -> IDLE.
//   Handshake: rx_ready=1 in IDLE, LEN, DATA and CSUM; rx_ready=0 in DONE and ERR.
//   A byte is consumed only when rx_valid and rx_ready are both high.
//   Timeout:
//   - The idle counter resets on every accepted byte and counts in LEN, DATA and CSUM.
//   - Reaching TIMEOUT_CYCLES -> ERR.
//   - A byte arriving on the same cycle the count reaches the limit is accepted; no timeout.
//   Read port:
//   - instr = (proc_ena && pc < prog_len) ? mem[pc] : 32'h0, combinational.
//   - Out-of-range pc and loading both give 0.
//   Back-to-back frames: a 0xA5 seen on the cycle after DONE or ERR is accepted normally.
//   Reset mid-frame: the FSM returns to IDLE and proc_ena=0. Partial memory writes remain
//   but are unreachable because prog_len=0.
// CONFIGURATION
//   WM_OPCODE_CHECK_EN
//   - Defined: each assembled word's opcode is checked when written. Legal opcodes are
//     01..05, 11, 12, 21, 22 (hex). An illegal opcode -> ERR on the cycle after the 4th
//     byte. The remaining frame bytes are discarded in IDLE.
//   - Undefined: no opcode check; any opcode is stored.
// STRUCTURE
//   wm_pkg (shared):
//   - opcode localparams (OP_WAIT 8'h01 ... OP_JNZ 8'h22)
//   - FRAME_HDR 8'hA5
//   - FSM state enum {IDLE, LEN, DATA, CSUM, DONE, ERR}
//   - instr field slice helpers
//   Sub-module wm_prog_ram: DEPTH x 32, one synchronous write port, one asynchronous read port.
//   The FSM, checksum, timeout and read gating live in wm_program_loader.
// TESTING
//   1 Frame A5,01,02,00,20,00,DD -> load_done pulse; pc=0 gives instr=32'h0020_0002,
//     proc_ena=1; pc=1 gives instr=0.
//   2 Frame A5,02,<11 00 AB 00>,<12 00 00 00>,CK=0x30 -> done; mem[0]=32'h00AB_0011,
//     mem[1]=32'h0000_0012.
//   3 Frame from test 1 with bad CK=0xDE -> load_err pulse, proc_ena=0, instr=0 for every pc.
//   4 A5,00 -> load_err pulse. A5,FF with DEPTH=16 -> load_err pulse.
//   5 A5,01,02 then silence for TIMEOUT_CYCLES -> load_err pulse. A following good frame
//     loads normally.
//   6 With WM_OPCODE_CHECK_EN: a word with opcode 8'h07 -> load_err pulse. Without the
//     macro: the same frame with a correct CK -> load_done pulse.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine program loader: opcodes, frame header,
// loader FSM states and instruction field helpers.
package wm_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  localparam logic [7:0] OP_WAIT  = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;
  localparam logic [7:0] OP_DRAIN = 8'h03;
  localparam logic [7:0] OP_HEAT  = 8'h04;
  localparam logic [7:0] OP_SPIN  = 8'h05;
  localparam logic [7:0] OP_LOAD  = 8'h11;
  localparam logic [7:0] OP_DEC   = 8'h12;
  localparam logic [7:0] OP_JMP   = 8'h21;
  localparam logic [7:0] OP_JNZ   = 8'h22;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Instruction word layout: {imm[15:0], reg[7:0], opcode[7:0]}
  function automatic logic [7:0] instr_opcode(input logic [31:0] w);
    return w[7:0];
  endfunction

  function automatic logic [7:0] instr_reg(input logic [31:0] w);
    return w[15:8];
  endfunction

  function automatic logic [15:0] instr_imm(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic opcode_legal(input logic [7:0] op);
    case (op)
      OP_WAIT, OP_FILL, OP_DRAIN, OP_HEAT, OP_SPIN,
      OP_LOAD, OP_DEC, OP_JMP, OP_JNZ: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wm_program_loader_if.sv
// Byte-stream interface from the byte source (master) to the program loader (slave).
interface wm_program_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/wm_prog_ram.sv
// Program store: DEPTH x 32, synchronous write port, asynchronous read port. Not reset.
module wm_prog_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Registered write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wm_program_loader.sv
// Receives a framed program (A5, N, 4*N bytes, CK) and writes it into the program store,
// serving instr for the processor's pc and gating the processor while loading / after a
// failed load. Optional build macro: WM_OPCODE_CHECK_EN rejects frames with illegal opcodes.
module wm_program_loader
  import wm_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  wm_program_loader_if.slave  rx,
  input  logic [7:0]          pc,
  output logic [31:0]         instr,
  output logic                proc_ena,
  output logic                load_done,
  output logic                load_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state, state_next;
  logic [7:0]  sum, sum_d;
  logic [7:0]  n_len, n_len_d;
  logic [7:0]  widx, widx_d;
  logic [1:0]  bcnt, bcnt_d;
  logic [23:0] asm_q, asm_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]  prog_len, prog_len_d;
  logic        proc_ena_d, load_done_d, load_err_d, rx_ready_d;
  logic        accept, timed_out, we;
  logic [31:0] word, rd_data;

  assign accept    = rx.rx_valid && rx.rx_ready;
  assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign word      = {rx.rx_data, asm_q};

  wm_prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (AW'(widx)),
    .wdata (word),
    .raddr (AW'(pc)),
    .rdata (rd_data)
  );

  // Out-of-range pc and a disabled processor both read as zero
  assign instr = (proc_ena && (pc < prog_len)) ? rd_data : 32'h0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, datapath and output next values
  always_comb begin
    state_next  = state;
    sum_d       = sum;
    n_len_d     = n_len;
    widx_d      = widx;
    bcnt_d      = bcnt;
    asm_d       = asm_q;
    cnt_d       = cnt;
    prog_len_d  = prog_len;
    proc_ena_d  = proc_ena;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    rx_ready_d  = 1'b1;
    we          = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept && (rx.rx_data == FRAME_HDR)) begin
          state_next = LEN;
          proc_ena_d = 1'b0;
          prog_len_d = 8'h00;
        end
      end
      LEN: begin
        if (accept) begin
          cnt_d = '0;
          if ((rx.rx_data == 8'h00) || (32'(rx.rx_data) > DEPTH)) begin
            state_next = ERR;
          end else begin
            n_len_d    = rx.rx_data;
            sum_d      = rx.rx_data;
            widx_d     = 8'h00;
            bcnt_d     = 2'd0;
            state_next = DATA;
          end
        end else if (timed_out) begin
          state_next = ERR;
        end else begin
          cnt_d = CW'(cnt + CW'(1));
        end
      end
      DATA: begin
        if (accept) begin
          cnt_d  = '0;
          sum_d  = 8'(sum + rx.rx_data);
          asm_d  = {rx.rx_data, asm_q[23:8]};
          bcnt_d = 2'(bcnt + 2'd1);
          if (bcnt == 2'd3) begin
            we     = 1'b1;
            widx_d = 8'(widx + 8'd1);
            if (8'(widx + 8'd1) == n_len) state_next = CSUM;
`ifdef WM_OPCODE_CHECK_EN
            if (!opcode_legal(instr_opcode(word))) state_next = ERR;
`endif
          end
        end else if (timed_out) begin
          state_next = ERR;
        end else begin
          cnt_d = CW'(cnt + CW'(1));
        end
      end
      CSUM: begin
        if (accept) begin
          cnt_d      = '0;
          state_next = (8'(sum + rx.rx_data) == 8'h00) ? DONE : ERR;
        end else if (timed_out) begin
          state_next = ERR;
        end else begin
          cnt_d = CW'(cnt + CW'(1));
        end
      end
      DONE:    begin cnt_d = '0; state_next = IDLE; end
      ERR:     begin cnt_d = '0; state_next = IDLE; end
      default: state_next = IDLE;
    endcase

    // Registered outputs track the state being entered
    if (state_next == DONE) begin
      load_done_d = 1'b1;
      proc_ena_d  = 1'b1;
      prog_len_d  = n_len;
    end
    if (state_next == ERR) load_err_d = 1'b1;
    if ((state_next == DONE) || (state_next == ERR)) rx_ready_d = 1'b0;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum         <= 8'h00;
      n_len       <= 8'h00;
      widx        <= 8'h00;
      bcnt        <= 2'd0;
      asm_q       <= 24'h0;
      cnt         <= '0;
      prog_len    <= 8'h00;
      proc_ena    <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      rx.rx_ready <= 1'b0;
    end else begin
      sum         <= sum_d;
      n_len       <= n_len_d;
      widx        <= widx_d;
      bcnt        <= bcnt_d;
      asm_q       <= asm_d;
      cnt         <= cnt_d;
      prog_len    <= prog_len_d;
      proc_ena    <= proc_ena_d;
      load_done   <= load_done_d;
      load_err    <= load_err_d;
      rx.rx_ready <= rx_ready_d;
    end
  end

endmodule

// File: tb/tb_wm_program_loader.sv
// Scoreboard bench for wm_program_loader: stimulus pushes expected load outcomes and
// read-back words; a negedge monitor pops and compares as the DUT presents them.
module tb_wm_program_loader;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 1000;

  typedef struct packed {
    logic done;
    logic err;
    logic ena;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc = 8'h00;
  logic [31:0] instr;
  logic        proc_ena, load_done, load_err;
  logic        rd_req = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_evt  = 0;
  int n_exp  = 0;

  evt_t        evt_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  fq[$];

  wm_program_loader_if rx_if();

  wm_program_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_if),
    .pc        (pc),
    .instr     (instr),
    .proc_ena  (proc_ena),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Monitor: load outcome pulses and requested instruction reads
  always @(negedge clk) begin
    evt_t e;
    logic [31:0] w;
    if (!rst && (load_done || load_err)) begin
      n_evt++;
      checks++;
      if (evt_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b, required no pulse", load_done, load_err);
      end else begin
        e = evt_q.pop_front();
        if (load_done !== e.done || load_err !== e.err || proc_ena !== e.ena) begin
          errors++;
          $display("FAIL load_outcome #%0d: got done=%0b err=%0b ena=%0b, required done=%0b err=%0b ena=%0b",
                   n_evt, load_done, load_err, proc_ena, e.done, e.err, e.ena);
        end
      end
    end
    if (rd_req) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_queue: read requested with no expectation");
      end else begin
        w = rd_q.pop_front();
        if (instr !== w) begin
          errors++;
          $display("FAIL instr pc=%0d: got %h, required %h", pc, instr, w);
        end
      end
    end
  end

  task automatic expect_evt(input logic done, input logic err, input logic ena);
    evt_t e;
    e.done = done; e.err = err; e.ena = ena;
    evt_q.push_back(e);
    n_exp++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int i;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_if.rx_ready) break;
    end
    if (i == 50) begin
      errors++;
      $display("FAIL rx_ready_wait: got rx_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_q();
    foreach (fq[i]) send_byte(fq[i]);
  endtask

  task automatic wait_all(input int budget);
    for (int i = 0; i < budget && n_evt < n_exp; i++) @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (n_evt != n_exp) begin
      errors++;
      $display("FAIL pulse_wait: got %0d pulses, required %0d", n_evt, n_exp);
      n_evt = n_exp;
      evt_q.delete();
    end
  endtask

  task automatic read_check(input logic [7:0] p, input logic [31:0] w);
    pc = p;
    rd_q.push_back(w);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic direct_check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    direct_check("reset_rx_ready", 32'(rx_if.rx_ready), 32'h0);
    direct_check("reset_proc_ena", 32'(proc_ena), 32'h0);
    direct_check("reset_load_done", 32'(load_done), 32'h0);
    direct_check("reset_load_err", 32'(load_err), 32'h0);
    direct_check("reset_instr", instr, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: single-word frame, with leading garbage discarded in IDLE
    fq = '{8'h33, 8'hA5, 8'h01, 8'h02, 8'h00, 8'h20, 8'h00, 8'hDD};
    expect_evt(1'b1, 1'b0, 1'b1);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0020_0002);
    read_check(8'd1, 32'h0);
    read_check(8'd255, 32'h0);

    // 2: two words, CK=0x30
    fq = '{8'hA5, 8'h02, 8'h11, 8'h00, 8'hAB, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h30};
    expect_evt(1'b1, 1'b0, 1'b1);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h00AB_0011);
    read_check(8'd1, 32'h0000_0012);
    read_check(8'd2, 32'h0);

    // 3: bad checksum
    fq = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h20, 8'h00, 8'hDE};
    expect_evt(1'b0, 1'b1, 1'b0);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0);
    read_check(8'd1, 32'h0);

    // 4: N=0, N=255, N=DEPTH+1, back to back
    fq = '{8'hA5, 8'h00, 8'hA5, 8'hFF, 8'hA5, 8'h11};
    expect_evt(1'b0, 1'b1, 1'b0);
    expect_evt(1'b0, 1'b1, 1'b0);
    expect_evt(1'b0, 1'b1, 1'b0);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0);

    // 5: silence inside a frame times out
    fq = '{8'hA5, 8'h01, 8'h02};
    expect_evt(1'b0, 1'b1, 1'b0);
    send_q();
    wait_all(TIMEOUT + 100);

    // 5b: gap of TIMEOUT-1 idle cycles is still tolerated
    expect_evt(1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    fq = '{8'h02, 8'h00, 8'h20, 8'h00, 8'hDD};
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0020_0002);

    // 6: opcode 0x07, CK=0xF8
    fq = '{8'hA5, 8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'hF8};
`ifdef WM_OPCODE_CHECK_EN
    expect_evt(1'b0, 1'b1, 1'b0);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0);
`else
    expect_evt(1'b1, 1'b0, 1'b1);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0000_0007);
`endif

    // Back-to-back: two-word frame then one-word frame; stale word 1 must be gated
    fq = '{8'hA5, 8'h02, 8'h11, 8'h00, 8'hAB, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h30,
           8'hA5, 8'h01, 8'h02, 8'h00, 8'h20, 8'h00, 8'hDD};
    expect_evt(1'b1, 1'b0, 1'b1);
    expect_evt(1'b1, 1'b0, 1'b1);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0020_0002);
    read_check(8'd1, 32'h0);

    // Reset in the middle of a frame
    fq = '{8'hA5, 8'h02, 8'h11};
    send_q();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    direct_check("midreset_proc_ena", 32'(proc_ena), 32'h0);
    rst = 1'b0;
    read_check(8'd0, 32'h0);
    fq = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h20, 8'h00, 8'hDD};
    expect_evt(1'b1, 1'b0, 1'b1);
    send_q();
    wait_all(100);
    read_check(8'd0, 32'h0020_0002);

    repeat (3) @(posedge clk);
    #1;
    direct_check("evt_q_drained", 32'(evt_q.size()), 32'h0);
    direct_check("rd_q_drained", 32'(rd_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
